// File: rtl/qif_pkg.sv
// Shared types, default constants and the saturation helper for the QIF neuron array.
package qif_pkg;

    localparam int unsigned DefW       = 8;
    localparam int unsigned DefN       = 4;
    localparam int unsigned DefShift   = 4;
    localparam int          DefVPeak   = 100;
    localparam int          DefVReset  = -64;
    localparam int unsigned DefRefrac  = 2;
    localparam int unsigned DefTickDiv = 8;

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } state_e;

    // Clamp a wide signed sum into the signed range of a w-bit word. The result stays wide
    // so callers of any width can take the low w bits.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] s,
                                                 input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/qif_update_core.sv
// Combinational update for one QIF neuron: quadratic integrate, saturate, fire, refractory.
module qif_update_core
    import qif_pkg::*;
#(
    parameter int unsigned W        = DefW,
    parameter int unsigned SHIFT    = DefShift,
    parameter int          V_PEAK   = DefVPeak,
    parameter int          V_RESET  = DefVReset,
    parameter int unsigned REFRAC   = DefRefrac,
    localparam int unsigned RW      = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic signed [W-1:0]  v,
    input  logic signed [W-1:0]  b,
    input  logic        [RW-1:0] r,
    output logic signed [W-1:0]  v_next,
    output logic        [RW-1:0] r_next,
    output logic                 fire
);

    // Two guard bits above the 2W-bit square keep the sum exact before saturation.
    localparam int unsigned SW = 2 * W + 2;

    logic signed [SW-1:0] v_x;
    logic signed [SW-1:0] b_x;
    logic signed [SW-1:0] sq_x;
    logic signed [SW-1:0] s;
    logic signed [63:0]   s_sat;

    // Compute the candidate membrane value and decide between hold-off, fire and integrate.
    always_comb begin
        v_x    = SW'(v);
        b_x    = SW'(b);
        sq_x   = (v_x * v_x) >>> SHIFT;
        s      = v_x + sq_x + b_x;
        s_sat  = sat_w(64'(s), W);
        v_next = s_sat[W-1:0];
        r_next = '0;
        fire   = 1'b0;
        if (r != '0) begin
            v_next = W'(V_RESET);
            r_next = r - RW'(1);
        end else if (s_sat >= 64'(V_PEAK)) begin
            // Threshold is checked after saturation, so an unreachable peak never fires.
            fire   = 1'b1;
            v_next = W'(V_RESET);
            r_next = RW'(REFRAC);
        end
    end

endmodule

// File: rtl/qif_neuron_array.sv
// N time-multiplexed QIF neurons sharing one update core, swept once per prescaler tick.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int unsigned W        = DefW,
    parameter int unsigned N        = DefN,
    parameter int unsigned SHIFT    = DefShift,
    parameter int          V_PEAK   = DefVPeak,
    parameter int          V_RESET  = DefVReset,
    parameter int unsigned REFRAC   = DefRefrac,
    parameter int unsigned TICK_DIV = DefTickDiv,
    localparam int unsigned SEL_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N*W-1:0]     b_in,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       v_sel,
    output logic [N*W-1:0]     v_all,
    output logic [N-1:0]       spike_vec,
    output logic               sweep_done
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    // A sweep must finish before the next tick can arrive.
    if (TICK_DIV < N + 1) begin : g_bad_tick_div
        $error("qif_neuron_array: TICK_DIV must be at least N+1");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tick;
    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [N-1:0]        acc_q, acc_d;
    logic [N-1:0]        spike_q, spike_d;
    logic                done_q, done_d;
    logic                upd_en;
    logic signed [W-1:0] v_q [N];
    logic [RW-1:0]       r_q [N];
    logic [W-1:0]        v_sel_q;

    logic signed [W-1:0] cur_v;
    logic signed [W-1:0] cur_b;
    logic [RW-1:0]       cur_r;
    logic signed [W-1:0] v_next;
    logic [RW-1:0]       r_next;
    logic                fire;

    assign cur_v = v_q[ptr_q];
    assign cur_b = b_in[int'(ptr_q) * W +: W];
    assign cur_r = r_q[ptr_q];
    assign tick  = ena && (cnt_q == CNT_W'(TICK_DIV - 1));

    qif_update_core #(
        .W       (W),
        .SHIFT   (SHIFT),
        .V_PEAK  (V_PEAK),
        .V_RESET (V_RESET),
        .REFRAC  (REFRAC)
    ) u_core (
        .v      (cur_v),
        .b      (cur_b),
        .r      (cur_r),
        .v_next (v_next),
        .r_next (r_next),
        .fire   (fire)
    );

    // Prescaler next count: wraps at TICK_DIV-1 and freezes while ena is low.
    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Sweep FSM next state: one channel per clock, publish spikes on the last one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        spike_d = spike_q;
        done_d  = 1'b0;
        upd_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                    acc_d   = '0;
                end
            end
            StSweep: begin
                upd_en = 1'b1;
                acc_d  = acc_q | (N'(fire) << ptr_q);
                if (ptr_q == PTR_W'(N - 1)) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                    spike_d = acc_d;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            ptr_q   <= '0;
            acc_q   <= '0;
            spike_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
            done_q  <= done_d;
        end
    end

    // Membrane and refractory register file, written back for the channel under update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                v_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else if (upd_en) begin
            v_q[ptr_q] <= v_next;
            r_q[ptr_q] <= r_next;
        end
    end

    // Monitor register: follows sel with one clock of latency, zero for out-of-range sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sel_q <= '0;
        end else if (int'(sel) < int'(N)) begin
            v_sel_q <= v_q[sel];
        end else begin
            v_sel_q <= '0;
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_v_all
        assign v_all[i*W +: W] = v_q[i];
    end

    assign v_sel      = v_sel_q;
    assign spike_vec  = spike_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array against a per-sweep arithmetic model.
module tb_qif_neuron_array;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena   = 1'b0;
    logic [N*W-1:0] b_in  = '0;
    logic [1:0]     sel   = '0;
    logic [W-1:0]   v_sel;
    logic [N*W-1:0] v_all;
    logic [N-1:0]   spike_vec;
    logic           sweep_done;

    qif_neuron_array #(
        .W        (8),
        .N        (4),
        .SHIFT    (4),
        .V_PEAK   (100),
        .V_RESET  (-64),
        .REFRAC   (2),
        .TICK_DIV (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .b_in       (b_in),
        .sel        (sel),
        .v_sel      (v_sel),
        .v_all      (v_all),
        .spike_vec  (spike_vec),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mv [N];
    int         mr [N];
    int         bv [N];
    logic [N-1:0] mspk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
        mspk = '0;
    endtask

    // One full sweep of the neuron equations with plain integer arithmetic.
    task automatic model_sweep();
        int s;
        for (int i = 0; i < N; i++) begin
            mspk[i] = 1'b0;
            if (mr[i] > 0) begin
                mv[i] = -64;
                mr[i] = mr[i] - 1;
            end else begin
                s = mv[i] + (mv[i] * mv[i]) / 16 + bv[i];
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
                if (s >= 100) begin
                    mspk[i] = 1'b1;
                    mv[i]   = -64;
                    mr[i]   = 2;
                end else begin
                    mv[i] = s;
                end
            end
        end
    endtask

    function automatic logic [N*W-1:0] model_pack();
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = 8'(mv[i]);
        return p;
    endfunction

    task automatic apply_b();
        for (int i = 0; i < N; i++) b_in[i*W +: W] = 8'(bv[i]);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_vall"}, longint'(model_pack()), longint'(v_all));
        check({tag, "_spk"}, longint'(spike_vec), longint'(mspk));
    endtask

    // Count clocks until sweep_done is seen, sampling 1 time unit after each rising edge.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sweep_done && n < 200);
        if (!sweep_done) check("done_timeout", longint'(sweep_done), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n;
        int seen;
        logic [W-1:0] exp8;

        // Reset state and idle sweep timing with zero input.
        ena = 1'b1;
        for (int i = 0; i < N; i++) bv[i] = 0;
        apply_b();
        do_reset();
        check("rst_vall", longint'(v_all), 0);
        check("rst_spk", longint'(spike_vec), 0);
        check("rst_done", longint'(sweep_done), 0);
        check("rst_vsel", longint'(v_sel), 0);
        wait_done(n);
        check("first_done_edge", n, 12);
        model_sweep();
        check_state("zero_s1");
        wait_done(n);
        check("done_period", n, 8);
        model_sweep();
        check_state("zero_s2");

        // B0 = 16: integrate, saturate and fire, refractory, fire again.
        bv = '{16, 0, 0, 0};
        apply_b();
        do_reset();
        for (int s = 1; s <= 7; s++) begin
            wait_done(n);
            model_sweep();
            check_state($sformatf("b16_s%0d", s));
            if (s == 3 || s == 6) check($sformatf("b16_fire_s%0d", s), longint'(spike_vec), 1);
            if (s == 4 || s == 5) check($sformatf("b16_refr_s%0d", s), longint'(v_all[7:0]), 8'hC0);
        end

        // B0 = -16: fixed point, never fires.
        bv = '{-16, 0, 0, 0};
        apply_b();
        do_reset();
        for (int s = 1; s <= 20; s++) begin
            wait_done(n);
            model_sweep();
            check_state($sformatf("neg16_s%0d", s));
        end
        check("neg16_v0", longint'(v_all[7:0]), 8'hF0);

        // B2 = 127: only channel 2 fires, neighbours untouched.
        bv = '{0, 0, 127, 0};
        apply_b();
        do_reset();
        wait_done(n);
        model_sweep();
        check("b2_spk", longint'(spike_vec), 4'b0100);
        check("b2_isolation", longint'(v_all & 32'hFF00_FFFF), 0);
        check_state("b2");

        // Asynchronous reset while channel 2 is the next to be updated.
        bv = '{16, 16, 0, 0};
        apply_b();
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("mid_pre_vall", longint'(v_all[15:0]), 16'h1010);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vall", longint'(v_all), 0);
        check("mid_rst_spk", longint'(spike_vec), 0);
        check("mid_rst_vsel", longint'(v_sel), 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen += int'(sweep_done);
        end
        check("mid_rst_nodone", seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_done(n);
        check("mid_rst_next_done", n, 12);
        model_sweep();
        check_state("mid_rst_s1");

        // Prescaler freeze for 20 clocks from idle, then resume from the held count.
        ena  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen += int'(sweep_done);
        end
        check("ena_low_nodone", seen, 0);
        check_state("ena_low_hold");
        ena = 1'b1;
        wait_done(n);
        check("ena_resume_done", n, 8);
        model_sweep();
        check_state("ena_resume");

        // Randomised currents and monitor selects.
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1, 0) == 1) bv[i] = int'($urandom_range(255, 0)) - 128;
                else                           bv[i] = int'($urandom_range(48, 0)) - 24;
            end
            apply_b();
            sel = 2'($urandom_range(3, 0));
            @(posedge clk);
            #1;
            exp8 = 8'(mv[sel]);
            check($sformatf("rnd_vsel_%0d", s), longint'(v_sel), longint'(exp8));
            wait_done(n);
            model_sweep();
            check_state($sformatf("rnd_s%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
